// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (Moore) with saturating hit counter.
// Latency: detected pulses the cycle after the posedge that accepted the final pattern bit.
// Backpressure: none; every bit offered with valid=1 is consumed, except during rst or cfg_load.
module seq_detector_param #(
    parameter int             N           = 5,
    parameter int             CW          = 8,
    parameter logic [N-1:0]   DEF_PATTERN = 5'b10011,
    parameter int             DEF_LEN     = 5,
    parameter logic           DEF_OVERLAP = 1'b1,
    localparam int            LW          = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          data,
    input  logic          valid,
    input  logic          cfg_load,
    input  logic [N-1:0]  cfg_pattern,
    input  logic [LW-1:0] cfg_len,
    input  logic          cfg_overlap,
    output logic          detected,
    output logic [CW-1:0] match_count
);

    localparam logic [LW-1:0] NMAX = LW'(N);

    // Active configuration, held together so a reload replaces it atomically.
    typedef struct packed {
        logic [N-1:0]  pat;
        logic [LW-1:0] len;
        logic          ovl;
    } cfg_t;

    cfg_t          cfg_q;
    logic [N-1:0]  hist_q;
    logic [N-1:0]  hist_nxt;
    logic [N-1:0]  len_mask;
    logic [LW-1:0] fill_q;
    logic [LW-1:0] fill_nxt;
    logic [LW-1:0] len_clamped;
    logic          match;

    // Mask selecting the low len bits of history/pattern that take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < N; i++) begin
            len_mask[i] = (LW'(i) < cfg_q.len);
        end
    end

    // Candidate next state for an accepted bit and the match decision it implies.
    // fill guards against matching on stale zeros left in hist after a restart.
    always_comb begin
        hist_nxt    = {hist_q[N-2:0], data};
        fill_nxt    = (fill_q >= NMAX) ? NMAX : fill_q + 1'b1;
        match       = (cfg_q.len != '0) && (fill_nxt >= cfg_q.len) &&
                      (((hist_nxt ^ cfg_q.pat) & len_mask) == '0);
        len_clamped = (cfg_len > NMAX) ? NMAX : cfg_len;
    end

    // Configuration, history, fill level, registered pulse and saturating hit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q.pat   <= DEF_PATTERN;
            cfg_q.len   <= LW'(DEF_LEN);
            cfg_q.ovl   <= DEF_OVERLAP;
            hist_q      <= '0;
            fill_q      <= '0;
            detected    <= 1'b0;
            match_count <= '0;
        end else if (cfg_load) begin
            cfg_q.pat   <= cfg_pattern;
            cfg_q.len   <= len_clamped;
            cfg_q.ovl   <= cfg_overlap;
            hist_q      <= '0;
            fill_q      <= '0;
            detected    <= 1'b0;
            match_count <= '0;
        end else if (valid) begin
            hist_q   <= hist_nxt;
            detected <= match;
            // Non-overlapping mode: a hit consumes its bits, so the next one needs len fresh bits.
            fill_q   <= (match && !cfg_q.ovl) ? '0 : fill_nxt;
            if (match && !(&match_count)) begin
                match_count <= match_count + 1'b1;
            end
        end else begin
            detected <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param with a queue-based reference model.
// Two instances share stimulus: default counter width and a 2-bit counter for saturation.
// Inputs change on negedge, model and DUT advance on posedge, outputs compared on negedge.
module tb_seq_detector_param;

    localparam int N  = 5;
    localparam int LW = $clog2(N + 1);

    logic          clk;
    logic          rst;
    logic          data;
    logic          valid;
    logic          cfg_load;
    logic [N-1:0]  cfg_pattern;
    logic [LW-1:0] cfg_len;
    logic          cfg_overlap;
    logic          det_a;
    logic [7:0]    cnt_a;
    logic          det_b;
    logic [1:0]    cnt_b;

    int nvec = 0;
    int nerr = 0;

    seq_detector_param #(.N(N), .CW(8)) dut_a (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .detected(det_a), .match_count(cnt_a)
    );

    seq_detector_param #(.N(N), .CW(2)) dut_b (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .detected(det_b), .match_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Keeps the accepted bits since the last restart in arrival order and asks
    // whether the most recent len of them spell the pattern, first bit = pat[len-1].
    bit          q[$];
    logic [N-1:0] m_pat;
    int          m_len;
    bit          m_ovl;
    bit          m_det;
    int          m_raw;
    bit          m_hit;
    bit          model_live = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_pat = 5'b10011; m_len = 5; m_ovl = 1'b1;
            q.delete(); m_det = 0; m_raw = 0; model_live = 1;
        end else if (cfg_load) begin
            m_pat = cfg_pattern;
            m_len = (int'(cfg_len) > N) ? N : int'(cfg_len);
            m_ovl = cfg_overlap;
            q.delete(); m_det = 0; m_raw = 0;
        end else if (valid) begin
            q.push_back(data);
            if (q.size() > N) void'(q.pop_front());
            m_hit = (m_len != 0) && (q.size() >= m_len);
            if (m_hit) begin
                for (int k = 0; k < m_len; k++) begin
                    if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k]) m_hit = 0;
                end
            end
            m_det = m_hit;
            if (m_hit) m_raw++;
            if (m_hit && !m_ovl) q.delete();
        end else begin
            m_det = 0;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (model_live) begin
            check("det_a", 32'(det_a), 32'(m_det));
            check("det_b", 32'(det_b), 32'(m_det));
            check("cnt_a", 32'(cnt_a), (m_raw > 255) ? 32'd255 : 32'(m_raw));
            check("cnt_b", 32'(cnt_b), (m_raw > 3) ? 32'd3 : 32'(m_raw));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic cl, input logic v, input logic d);
        rst = r; cfg_load = cl; valid = v; data = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [N-1:0] p, input logic [LW-1:0] l, input logic o);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Feed n bits, MSB of bits first; dets[i] is the detected output after bit i.
    task automatic feed(input logic [15:0] bits, input int n, output logic [15:0] dets);
        dets = '0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b1, bits[n - 1 - i]);
            dets[i] = det_a;
        end
    endtask

    logic [15:0] dets;

    initial begin
        rst = 1'b1; cfg_load = 1'b0; valid = 1'b0; data = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        @(negedge clk);
        check("reset_det", 32'(det_a), 32'd0);
        check("reset_cnt", 32'(cnt_a), 32'd0);

        // 1: default 10011, overlapping, two hits sharing bits
        feed(16'b100110011, 9, dets);
        check("t1_pulses", 32'(dets), 32'h0110);
        check("t1_cnt", 32'(cnt_a), 32'd2);

        // 2: 101 non-overlapping then overlapping
        load(5'b00101, 3'd3, 1'b0);
        feed(16'b10101, 5, dets);
        check("t2_nonovl_pulses", 32'(dets), 32'h0004);
        check("t2_nonovl_cnt", 32'(cnt_a), 32'd1);
        load(5'b00101, 3'd3, 1'b1);
        feed(16'b10101, 5, dets);
        check("t2_ovl_pulses", 32'(dets), 32'h0014);
        check("t2_ovl_cnt", 32'(cnt_a), 32'd2);

        // 3: valid gaps with data toggling while idle
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            logic [4:0] pat5;
            pat5 = 5'b10011;
            step(1'b0, 1'b0, 1'b1, pat5[4 - i]);
            if (i == 4) check("t3_pulse", 32'(det_a), 32'd1);
            step(1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("t3_idle_nopulse", 32'(det_a), 32'd0);
        check("t3_cnt", 32'(cnt_a), 32'd1);

        // 4: reset mid-pattern, then reset restores defaults after a custom config
        feed(16'b1001, 4, dets);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        feed(16'b1, 1, dets);
        check("t4_no_cross_rst", 32'(dets), 32'h0000);
        check("t4_cnt", 32'(cnt_a), 32'd0);
        load(5'b00111, 3'd3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        feed(16'b10011, 5, dets);
        check("t4_defaults_back", 32'(dets), 32'h0010);

        // 5: len=0 disabled, len>N clamps, len=1 with counter saturation
        load(5'b10011, 3'd0, 1'b1);
        feed(16'b1001110011111111, 16, dets);
        check("t5_disabled", 32'(dets), 32'h0000);
        check("t5_disabled_cnt", 32'(cnt_a), 32'd0);
        load(5'b10011, 3'd7, 1'b1);
        feed(16'b10011, 5, dets);
        check("t5_clamp", 32'(dets), 32'h0010);
        load(5'b00001, 3'd1, 1'b1);
        feed(16'b111111, 6, dets);
        check("t5_len1_pulses", 32'(dets), 32'h003F);
        check("t5_sat_b", 32'(cnt_b), 32'd3);
        check("t5_cnt_a", 32'(cnt_a), 32'd6);
        for (int i = 0; i < 260; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        check("t5_sat_a", 32'(cnt_a), 32'd255);

        // 6: bit offered during cfg_load is dropped; rst beats cfg_load
        cfg_pattern = 5'b00011; cfg_len = 3'd2; cfg_overlap = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        feed(16'b1, 1, dets);
        check("t6_load_drops_bit", 32'(dets), 32'h0000);
        feed(16'b1, 1, dets);
        check("t6_second_bit_hits", 32'(dets), 32'h0001);
        cfg_pattern = 5'b00000; cfg_len = 3'd1; cfg_overlap = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        feed(16'b10011, 5, dets);
        check("t6_rst_wins", 32'(dets), 32'h0010);
        check("t6_cnt", 32'(cnt_a), 32'd1);

        step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
